// File: rtl/pocket_sequencer_if.sv
// Bus between the pocket sequencer and the rest of the video pipeline.
// The master side drives the frame pulse, the draw requests and newGame.
// The slave side returns the visibility gates, hole highlights, respawn
// pulses and the game counters.
interface pocket_sequencer_if;
    logic       startOfFrame;
    logic [5:0] holeDR;
    logic       whiteBallDR;
    logic       redBallDR;
    logic       newGame;
    logic       whiteVisible;
    logic       redVisible;
    logic [5:0] holeHighlight;
    logic       freezeMotion;
    logic       whiteRespawn;
    logic       redRespawn;
    logic [3:0] score;
    logic [3:0] foulCount;
    logic       gameOver;

    modport master (
        output startOfFrame, holeDR, whiteBallDR, redBallDR, newGame,
        input  whiteVisible, redVisible, holeHighlight, freezeMotion,
               whiteRespawn, redRespawn, score, foulCount, gameOver
    );

    modport slave (
        input  startOfFrame, holeDR, whiteBallDR, redBallDR, newGame,
        output whiteVisible, redVisible, holeHighlight, freezeMotion,
               whiteRespawn, redRespawn, score, foulCount, gameOver
    );
endinterface

// File: rtl/pocket_sequencer.sv
// Game-flow controller for the pool table.
// It detects a ball falling into a pocket from the overlap of the hole and
// ball draw requests. It then freezes physics, blinks the sunk ball and
// lights the capturing hole. Afterwards it scores or counts a foul,
// respawns the ball, and ends the game once enough reds have been potted.
module pocket_sequencer #(
    parameter int SINK_FRAMES    = 32,
    parameter int BLINK_FRAMES   = 4,
    parameter int RESPAWN_FRAMES = 16,
    parameter int WIN_SCORE      = 5
) (
    input  logic              clk,
    input  logic              reset,
    pocket_sequencer_if.slave bus
);
    typedef enum logic [1:0] {PLAY, SINK, RESPAWN, OVER} state_t;

    localparam logic [7:0] SINK_LAST    = 8'(SINK_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST   = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
    localparam logic [3:0] WIN          = 4'(WIN_SCORE);

    state_t     state;
    logic [7:0] cnt;
    // blinkCnt/blinkPhase track (cnt / BLINK_FRAMES) without a divider
    logic [7:0] blinkCnt;
    logic       blinkPhase;
    logic       whiteHit, redHit;
    logic [5:0] hitHoles;
    logic       sinkWhite, sinkRed;

    logic       whiteVisible, redVisible, freezeMotion, gameOver;
    logic       whiteRespawn, redRespawn;
    logic [5:0] holeHighlight;
    logic [3:0] score, foulCount;

    logic       wHitNow, rHitNow, anyHitNow, phaseNext;
    logic [3:0] scoreInc, foulInc;

    assign wHitNow   = bus.whiteBallDR & whiteVisible & (|bus.holeDR);
    assign rHitNow   = bus.redBallDR & redVisible & (|bus.holeDR);
    assign anyHitNow = wHitNow | rHitNow;
    assign phaseNext = blinkPhase ^ (blinkCnt == BLINK_LAST);
    assign scoreInc  = (score == 4'hF) ? score : score + 4'd1;
    assign foulInc   = (foulCount == 4'hF) ? foulCount : foulCount + 4'd1;

    assign bus.whiteVisible  = whiteVisible;
    assign bus.redVisible    = redVisible;
    assign bus.holeHighlight = holeHighlight;
    assign bus.freezeMotion  = freezeMotion;
    assign bus.whiteRespawn  = whiteRespawn;
    assign bus.redRespawn    = redRespawn;
    assign bus.score         = score;
    assign bus.foulCount     = foulCount;
    assign bus.gameOver      = gameOver;

    // Game-flow FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= PLAY;
            cnt           <= 8'd0;
            blinkCnt      <= 8'd0;
            blinkPhase    <= 1'b0;
            whiteHit      <= 1'b0;
            redHit        <= 1'b0;
            hitHoles      <= 6'd0;
            sinkWhite     <= 1'b0;
            sinkRed       <= 1'b0;
            whiteVisible  <= 1'b1;
            redVisible    <= 1'b1;
            holeHighlight <= 6'd0;
            freezeMotion  <= 1'b0;
            whiteRespawn  <= 1'b0;
            redRespawn    <= 1'b0;
            score         <= 4'd0;
            foulCount     <= 4'd0;
            gameOver      <= 1'b0;
        end else begin
            whiteRespawn <= 1'b0;
            redRespawn   <= 1'b0;
            case (state)
                PLAY: begin
                    if (bus.startOfFrame) begin
                        if (whiteHit | redHit) begin
                            sinkWhite     <= whiteHit;
                            sinkRed       <= redHit;
                            holeHighlight <= hitHoles;
                            freezeMotion  <= 1'b1;
                            cnt           <= 8'd0;
                            blinkCnt      <= 8'd0;
                            blinkPhase    <= 1'b0;
                            whiteHit      <= 1'b0;
                            redHit        <= 1'b0;
                            hitHoles      <= 6'd0;
                            state         <= SINK;
                        end else begin
                            // a hit on the frame pulse opens the next frame's accumulation
                            whiteHit <= wHitNow;
                            redHit   <= rHitNow;
                            hitHoles <= anyHitNow ? bus.holeDR : 6'd0;
                        end
                    end else begin
                        whiteHit <= whiteHit | wHitNow;
                        redHit   <= redHit | rHitNow;
                        if (anyHitNow)
                            hitHoles <= hitHoles | bus.holeDR;
                    end
                end
                SINK: begin
                    if (bus.startOfFrame) begin
                        if (cnt == SINK_LAST) begin
                            if (sinkWhite) begin
                                foulCount    <= foulInc;
                                whiteVisible <= 1'b0;
                            end
                            if (sinkRed) begin
                                score      <= scoreInc;
                                redVisible <= 1'b0;
                            end
                            holeHighlight <= 6'd0;
                            cnt           <= 8'd0;
                            if (sinkRed && scoreInc >= WIN) begin
                                whiteVisible <= 1'b0;
                                redVisible   <= 1'b0;
                                gameOver     <= 1'b1;
                                state        <= OVER;
                            end else begin
                                state <= RESPAWN;
                            end
                        end else begin
                            cnt        <= cnt + 8'd1;
                            blinkCnt   <= (blinkCnt == BLINK_LAST) ? 8'd0 : blinkCnt + 8'd1;
                            blinkPhase <= phaseNext;
                            if (sinkWhite)
                                whiteVisible <= ~phaseNext;
                            if (sinkRed)
                                redVisible <= ~phaseNext;
                        end
                    end
                end
                RESPAWN: begin
                    if (bus.startOfFrame) begin
                        if (cnt == RESPAWN_LAST) begin
                            whiteRespawn <= sinkWhite;
                            redRespawn   <= sinkRed;
                            whiteVisible <= 1'b1;
                            redVisible   <= 1'b1;
                            freezeMotion <= 1'b0;
                            cnt          <= 8'd0;
                            state        <= PLAY;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                OVER: begin
                    if (bus.newGame) begin
                        score        <= 4'd0;
                        foulCount    <= 4'd0;
                        whiteRespawn <= 1'b1;
                        redRespawn   <= 1'b1;
                        whiteVisible <= 1'b1;
                        redVisible   <= 1'b1;
                        freezeMotion <= 1'b0;
                        gameOver     <= 1'b0;
                        whiteHit     <= 1'b0;
                        redHit       <= 1'b0;
                        hitHoles     <= 6'd0;
                        state        <= PLAY;
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end
endmodule

// File: tb/tb_pocket_sequencer.sv
// Directed bench for pocket_sequencer: a table of frame-level steps with
// hand-computed expected outputs, plus hand-written reset and frame-pulse
// corner sequences.
module tb_pocket_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pocket_sequencer_if bus();
    pocket_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int         fr;
        bit         ng;
        logic [5:0] h;
        logic       w, r;
        logic       wv, rv;
        logic [5:0] hl;
        logic       frz;
        logic [3:0] sc, fl;
        logic       go;
        int         wr, rr, bo;
    } vec_t;

    vec_t tbl[23];
    int checks = 0;
    int errors = 0;
    int wrCnt = 0, rrCnt = 0, boCnt = 0;

    // count respawn pulse cycles
    always @(posedge clk) begin
        if (bus.whiteRespawn) wrCnt <= wrCnt + 1;
        if (bus.redRespawn) rrCnt <= rrCnt + 1;
        if (bus.whiteRespawn && bus.redRespawn) boCnt <= boCnt + 1;
    end

    function automatic vec_t V(int fr, bit ng, logic [5:0] h, logic w, logic r,
                               logic wv, logic rv, logic [5:0] hl, logic frz,
                               logic [3:0] sc, logic [3:0] fl, logic go,
                               int wr, int rr, int bo);
        vec_t v;
        v.fr = fr; v.ng = ng; v.h = h; v.w = w; v.r = r;
        v.wv = wv; v.rv = rv; v.hl = hl; v.frz = frz;
        v.sc = sc; v.fl = fl; v.go = go; v.wr = wr; v.rr = rr; v.bo = bo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one frame: pulse, then three cycles of draw requests
    task automatic run_frame(input logic [5:0] h, input logic w, input logic r);
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        bus.holeDR = 6'd0; bus.whiteBallDR = 1'b0; bus.redBallDR = 1'b0;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        bus.holeDR = h; bus.whiteBallDR = w; bus.redBallDR = r;
        repeat (2) @(negedge clk);
        @(negedge clk);
        bus.holeDR = 6'd0; bus.whiteBallDR = 1'b0; bus.redBallDR = 1'b0;
    endtask

    task automatic chk_outs(input string t, input logic wv, input logic rv,
                            input logic [5:0] hl, input logic frz,
                            input logic [3:0] sc, input logic [3:0] fl, input logic go);
        chk({t, ".wv"}, int'(bus.whiteVisible), int'(wv));
        chk({t, ".rv"}, int'(bus.redVisible), int'(rv));
        chk({t, ".hl"}, int'(bus.holeHighlight), int'(hl));
        chk({t, ".frz"}, int'(bus.freezeMotion), int'(frz));
        chk({t, ".sc"}, int'(bus.score), int'(sc));
        chk({t, ".fl"}, int'(bus.foulCount), int'(fl));
        chk({t, ".go"}, int'(bus.gameOver), int'(go));
    endtask

    initial begin
        // single white foul, hole 3, with blink and stray overlaps
        tbl[0]  = V(1,  0, 6'h04, 1, 0, 1, 1, 6'h00, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = V(1,  0, 6'h00, 0, 0, 1, 1, 6'h04, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = V(4,  0, 6'h00, 0, 0, 0, 1, 6'h04, 1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = V(4,  0, 6'h00, 0, 0, 1, 1, 6'h04, 1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = V(4,  0, 6'h00, 0, 0, 0, 1, 6'h04, 1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = V(19, 0, 6'h02, 1, 1, 0, 1, 6'h04, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = V(1,  0, 6'h00, 0, 0, 0, 1, 6'h00, 1, 0, 1, 0, 0, 0, 0);
        tbl[7]  = V(15, 0, 6'h00, 0, 0, 0, 1, 6'h00, 1, 0, 1, 0, 0, 0, 0);
        tbl[8]  = V(1,  0, 6'h00, 0, 0, 1, 1, 6'h00, 0, 0, 1, 0, 1, 0, 0);
        tbl[9]  = V(2,  0, 6'h00, 1, 1, 1, 1, 6'h00, 0, 0, 1, 0, 1, 0, 0);
        tbl[10] = V(2,  0, 6'h00, 0, 0, 1, 1, 6'h00, 0, 0, 1, 0, 1, 0, 0);
        // five red pockets to game over, then newGame
        tbl[11] = V(50, 0, 6'h01, 0, 1, 1, 1, 6'h00, 0, 1, 1, 0, 1, 1, 0);
        tbl[12] = V(50, 0, 6'h01, 0, 1, 1, 1, 6'h00, 0, 2, 1, 0, 1, 2, 0);
        tbl[13] = V(50, 0, 6'h01, 0, 1, 1, 1, 6'h00, 0, 3, 1, 0, 1, 3, 0);
        tbl[14] = V(50, 0, 6'h01, 0, 1, 1, 1, 6'h00, 0, 4, 1, 0, 1, 4, 0);
        tbl[15] = V(34, 0, 6'h01, 0, 1, 0, 0, 6'h00, 1, 5, 1, 1, 1, 4, 0);
        tbl[16] = V(3,  0, 6'h00, 0, 0, 0, 0, 6'h00, 1, 5, 1, 1, 1, 4, 0);
        tbl[17] = V(0,  1, 6'h00, 0, 0, 1, 1, 6'h00, 0, 0, 0, 0, 2, 5, 1);
        tbl[18] = V(0,  1, 6'h00, 0, 0, 1, 1, 6'h00, 0, 0, 0, 0, 2, 5, 1);
        // both balls into holes 1 and 6 together
        tbl[19] = V(2,  0, 6'h21, 1, 1, 1, 1, 6'h21, 1, 0, 0, 0, 2, 5, 1);
        tbl[20] = V(4,  0, 6'h00, 0, 0, 0, 0, 6'h21, 1, 0, 0, 0, 2, 5, 1);
        tbl[21] = V(28, 0, 6'h00, 0, 0, 0, 0, 6'h00, 1, 1, 1, 0, 2, 5, 1);
        tbl[22] = V(16, 0, 6'h00, 0, 0, 1, 1, 6'h00, 0, 1, 1, 0, 3, 6, 2);

        reset = 1'b1;
        bus.startOfFrame = 1'b0; bus.holeDR = 6'd0;
        bus.whiteBallDR = 1'b0; bus.redBallDR = 1'b0; bus.newGame = 1'b0;
        repeat (3) @(negedge clk);
        chk_outs("reset", 1, 1, 6'h00, 0, 0, 0, 0);
        chk("reset.wresp", int'(bus.whiteRespawn), 0);
        chk("reset.rresp", int'(bus.redRespawn), 0);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            if (tbl[i].ng) begin
                @(negedge clk); bus.newGame = 1'b1;
                @(negedge clk); bus.newGame = 1'b0;
                @(negedge clk);
            end else begin
                for (int f = 0; f < tbl[i].fr; f++)
                    if (f == 0) run_frame(tbl[i].h, tbl[i].w, tbl[i].r);
                    else run_frame(6'h00, 1'b0, 1'b0);
            end
            chk_outs($sformatf("v%0d", i), tbl[i].wv, tbl[i].rv, tbl[i].hl,
                     tbl[i].frz, tbl[i].sc, tbl[i].fl, tbl[i].go);
            chk($sformatf("v%0d.wrcnt", i), wrCnt, tbl[i].wr);
            chk($sformatf("v%0d.rrcnt", i), rrCnt, tbl[i].rr);
            chk($sformatf("v%0d.both", i), boCnt, tbl[i].bo);
        end

        // reset during the 10th SINK frame
        run_frame(6'h08, 1'b1, 1'b0);
        run_frame(6'h00, 1'b0, 1'b0);
        chk("midsink.frz", int'(bus.freezeMotion), 1);
        repeat (9) run_frame(6'h00, 1'b0, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk_outs("midreset", 1, 1, 6'h00, 0, 0, 0, 0);
        chk("midreset.wresp", int'(bus.whiteRespawn), 0);
        chk("midreset.rresp", int'(bus.redRespawn), 0);
        run_frame(6'h00, 1'b0, 1'b0);
        chk("postreset.frz", int'(bus.freezeMotion), 0);
        chk("postreset.hl", int'(bus.holeHighlight), 0);

        // hit on the frame pulse cycle enters SINK one frame later
        @(negedge clk);
        bus.startOfFrame = 1'b1; bus.holeDR = 6'h10; bus.whiteBallDR = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0; bus.holeDR = 6'h00; bus.whiteBallDR = 1'b0;
        repeat (3) @(negedge clk);
        chk("sofhit.frz0", int'(bus.freezeMotion), 0);
        chk("sofhit.hl0", int'(bus.holeHighlight), 0);
        run_frame(6'h00, 1'b0, 1'b0);
        chk("sofhit.frz1", int'(bus.freezeMotion), 1);
        chk("sofhit.hl1", int'(bus.holeHighlight), 6'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
